// File: rtl/alu_pkg.sv
// alu_pkg -- definitions shared by the ALU and the control unit.
//   * default datapath width
//   * op code constants OP_ADD .. OP_MUL (3 bits)
//   * FSM state type used by the iterative multiplier
package alu_pkg;

    localparam int WIDTH_DEFAULT = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/mul_seq_16.sv
// mul_seq_16 -- unsigned shift-add iterative multiplier.
// One iteration per clock; WIDTH iterations per product.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin a multiply (only honoured while idle)
//   a, b          multiplicand / multiplier, captured on an accepted start
//   busy          registered: a multiply is in flight
//   done          high during the final iteration cycle; the product is
//                 registered by the parent on that same edge
//   product       2*WIDTH-bit value the accumulator takes on this edge;
//                 equals the full product while done=1
module mul_seq_16
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t                 state_reg, state_next;
    logic [2*WIDTH-1:0]     mcand_reg, mcand_next;
    logic [WIDTH-1:0]       mplier_reg, mplier_next;
    logic [2*WIDTH-1:0]     acc_reg, acc_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]     addend;
    logic [2*WIDTH-1:0]     acc_step;

    // Partial product of this iteration: the shifted multiplicand gated by
    // the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign acc_step = acc_reg + addend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        done        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = MUL;
                    mcand_next  = {{WIDTH{1'b0}}, a};
                    mplier_next = b;
                    acc_next    = '0;
                    cnt_next    = '0;
                end
            end
            MUL: begin
                acc_next    = acc_step;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == LAST_ITER) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state_reg == MUL);
    assign product = acc_step;

endmodule

// File: rtl/alu_16.sv
// alu_16 -- sequential ALU for the single-cycle datapath.
// Single-cycle ops finish one edge after start; MUL runs on mul_seq_16 for
// WIDTH cycles while busy stalls the control unit.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         request, sampled only while busy=0
//   op            operation code (alu_pkg OP_*), latched on accepted start
//   a, b          operands (b from the operand mux), latched on accepted start
//   result        registered result, held until the next done
//   zero          registered, result==0
//   carry         registered, op-dependent flag
//   busy          multiply in progress
//   done          one-cycle pulse when result/zero/carry update
module alu_16
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              carry,
    output logic              busy,
    output logic              done
);

    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg;
    logic               carry_reg;
    logic               done_reg;

    logic               mul_busy;
    logic               mul_done;
    logic               mul_start;
    logic [2*WIDTH-1:0] mul_product;

    logic               accept_single;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [3:0]         shamt;
    logic [WIDTH:0]     sll_wide;
    logic [WIDTH:0]     srl_wide;

    assign mul_start     = start && !mul_busy && (op == OP_MUL);
    assign accept_single = start && !mul_busy && (op != OP_MUL);

    mul_seq_16 #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Shifts carry one guard bit so the last bit shifted out lands in a
    // fixed position; with shamt=0 the guard bit stays 0.
    assign shamt    = b[3:0];
    assign sll_wide = {1'b0, a} << shamt;
    assign srl_wide = {a, 1'b0} >> shamt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
            // Top bit of the widened difference is the unsigned borrow.
            OP_SUB: {alu_c, alu_res} = {1'b0, a} - {1'b0, b};
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLL: {alu_c, alu_res} = sll_wide;
            OP_SRL: begin
                alu_res = srl_wide[WIDTH:1];
                alu_c   = srl_wide[0];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept_single) begin
                result_reg <= alu_res;
                zero_reg   <= (alu_res == '0);
                carry_reg  <= alu_c;
                done_reg   <= 1'b1;
            end else if (mul_done) begin
                result_reg <= mul_product[WIDTH-1:0];
                zero_reg   <= (mul_product[WIDTH-1:0] == '0);
                carry_reg  <= |mul_product[2*WIDTH-1:WIDTH];
                done_reg   <= 1'b1;
            end
        end
    end

    assign result = result_reg;
    assign zero   = zero_reg;
    assign carry  = carry_reg;
    assign done   = done_reg;
    assign busy   = mul_busy;

endmodule

// File: tb/tb_alu_16.sv
// tb_alu_16 -- self-checking bench for alu_16: directed cases plus
// randomized operations against an arithmetic reference model.
module tb_alu_16;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  result;
    logic          zero;
    logic          carry;
    logic          busy;
    logic          done;

    int n_vec;
    int n_err;

    alu_16 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .zero   (zero),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model from the operation definitions, in plain integers.
    function automatic void model(input int o, input int x, input int y,
                                  output int r, output int c);
        longint p;
        int sh;
        sh = y % 16;
        c = 0;
        case (o)
            0: begin r = (x + y) % 65536; c = (x + y >= 65536) ? 1 : 0; end
            1: begin r = (x - y + 65536) % 65536; c = (x < y) ? 1 : 0; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin
                r = (x * (1 << sh)) % 65536;
                c = (sh == 0) ? 0 : ((x >> (16 - sh)) & 1);
            end
            6: begin
                r = x / (1 << sh);
                c = (sh == 0) ? 0 : ((x >> (sh - 1)) & 1);
            end
            default: begin
                p = longint'(x) * longint'(y);
                r = int'(p % 65536);
                c = (p >= 65536) ? 1 : 0;
            end
        endcase
    endfunction

    // Called at a falling edge; leaves the bench at the falling edge of the
    // done cycle, so a following call starts back-to-back.
    task automatic run_op(input int o, input int x, input int y, input bit inj);
        int er, ec, lat, bc;
        model(o, x, y, er, ec);
        start = 1'b1;
        op    = 3'(o);
        a     = W'(x);
        b     = W'(y);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        op    = 3'($urandom);
        if (o != 7) begin
            check("done_lat1", 32'(done), 32'd1);
            check("busy_single", 32'(busy), 32'd0);
        end else begin
            lat = 0;
            bc  = 0;
            while (!done && lat < W + 4) begin
                if (busy) bc++;
                start = 1'b0;
                if (inj && (lat == 2 || lat == 8)) begin
                    start = 1'b1;
                    op    = 3'($urandom);
                end
                a = W'($urandom);
                b = W'($urandom);
                @(negedge clk);
                lat++;
            end
            start = 1'b0;
            check("mul_latency", 32'(lat), 32'(W));
            check("busy_cycles", 32'(bc), 32'(W));
            check("busy_at_done", 32'(busy), 32'd0);
        end
        check("result", 32'(result), 32'(er));
        check("zero", 32'(zero), (er == 0) ? 32'd1 : 32'd0);
        check("carry", 32'(carry), 32'(ec));
        $display("op=%0d a=0x%04h b=0x%04h -> result=0x%04h zero=%0d carry=%0d (exp 0x%04h c=%0d)",
                 o, x, y, result, zero, carry, er, ec);
    endtask

    // Idle cycles in which no done may appear.
    task automatic idle_no_done(input int n, input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        int ro, rx, ry;
        int dcnt;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 16'hFFFF, 16'h0001, 1'b0);
        idle_no_done(1, "done_one_cycle");
        run_op(1, 16'h0003, 16'h0005, 1'b0);
        run_op(5, 16'h8001, 16'h0001, 1'b0);
        run_op(7, 16'h0123, 16'h0010, 1'b0);
        run_op(7, 16'h1000, 16'h0100, 1'b0);
        idle_no_done(1, "mul_done_one_cycle");

        // Ignored starts and toggled operands during a multiply.
        run_op(7, 16'h00FF, 16'h0101, 1'b1);
        idle_no_done(4, "no_extra_done");

        // Back-to-back: ADD started in the MUL done cycle.
        run_op(7, 16'h0123, 16'h0010, 1'b0);
        run_op(0, 16'h0002, 16'h0003, 1'b0);
        idle_no_done(1, "b2b_done_one_cycle");

        // Reset in the middle of a multiply.
        start = 1'b1;
        op    = 3'd7;
        a     = 16'h0123;
        b     = 16'h0010;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_zero", 32'(zero), 32'd0);
        check("midrst_carry", 32'(carry), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        dcnt = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("midrst_no_done", 32'(dcnt), 32'd0);
        run_op(0, 16'h0007, 16'h0009, 1'b0);

        // Randomized operations, back-to-back.
        for (int i = 0; i < 60; i++) begin
            ro = int'($urandom_range(0, 7));
            rx = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) ry = int'($urandom_range(0, 15));
            else ry = int'($urandom_range(0, 65535));
            run_op(ro, rx, ry, 1'(($urandom_range(0, 3) == 0)));
        end
        idle_no_done(2, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_16.md
# alu_16

- Sequential 16-bit ALU for the single-cycle processor datapath.
- Sits directly downstream of the operand-B mux:
  - operand A comes from register-file read port 1;
  - operand B is the mux output, i.e. a register value or a zero-extended 4-bit immediate.
- Executes add/sub/logic/shift ops in one cycle and multiply iteratively over WIDTH cycles.
- Uses a start/busy/done handshake so the control unit can stall the PC while a multiply is in flight.

## Interface
Parameters:
- WIDTH, 16, datapath width; multiply takes WIDTH iteration cycles.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle (busy=0).
- op  input  3  operation code, latched on accepted start.
- a  input  WIDTH  operand A, latched on accepted start.
- b  input  WIDTH  operand B from the operand mux, latched on accepted start.
- result  output  WIDTH  registered result; holds until the next done.
- zero  output  1  registered; result==0.
- carry  output  1  registered; op-dependent flag (see Operation).
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when result/zero/carry update.

## Operation
- op encodings:
  - 000 ADD: result = a+b; carry = bit WIDTH of the sum.
  - 001 SUB: result = a−b mod 2^WIDTH; carry = borrow (a<b unsigned).
  - 010 AND; 011 OR; 100 XOR: carry = 0.
  - 101 SLL by b[3:0]: carry = last bit shifted out; 0 if shamt = 0.
  - 110 SRL by b[3:0]: carry = last bit shifted out; 0 if shamt = 0.
  - 111 MUL: result = low WIDTH bits of unsigned a*b; carry = |(high WIDTH bits).
- zero is computed from the final result for every op.
- FSM states: IDLE, MUL.
  - IDLE, start=1, op≠MUL: compute combinationally, register result/flags, pulse done; stay IDLE.
  - IDLE, start=1, op=MUL: latch a, b; clear accumulator and counter; go to MUL; busy=1.
  - MUL: each cycle, if multiplier LSB=1 add the shifted multiplicand into the 2·WIDTH accumulator; shift; increment counter.
  - MUL, counter==WIDTH−1: register result/flags, pulse done, go to IDLE, busy=0.
- start while busy=1: ignored; no queuing.
- a, b and op may change freely while busy; latched copies are used.
- Back-to-back: start asserted in the done cycle is accepted, because the state is already IDLE.
- rst (any state, including mid-multiply): state=IDLE, result=0, zero=0, carry=0, busy=0, done=0, counter=0; in-flight multiply discarded, no done.

## Timing
- Start accepted at edge k.
- Non-MUL: done=1 and result valid in the cycle after edge k; latency 1.
- MUL:
  - busy=1 after edge k through edge k+WIDTH.
  - Iterations occur at edges k+1..k+WIDTH.
  - done=1 and busy=0 after edge k+WIDTH; latency 16 for WIDTH=16.
- done is high for exactly one cycle per accepted start.
- result/zero/carry change only on the edge that raises done, or on rst.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package alu_pkg:
  - op code constants: OP_ADD..OP_MUL;
  - FSM state typedef: IDLE, MUL;
  - default WIDTH.
- Sub-module mul_seq_16 (shift-add iterative multiplier) with its own start/done.
  - alu_16 wraps it and muxes in the single-cycle ops.
  - The control unit imports alu_pkg for op encoding.

## Test plan
- ADD 0xFFFF+0x0001 -> result 0x0000, zero=1, carry=1, done one cycle after start.
- SUB 0x0003−0x0005 -> result 0xFFFE, carry=1, zero=0; then SLL 0x8001 by b=0x0001 (immediate path) -> result 0x0002, carry=1.
- MUL 0x0123*0x0010 -> busy high 16 cycles, done on cycle 16, result 0x1230, carry=0; MUL 0x1000*0x0100 -> result 0x0000, zero=1, carry=1.
- Start asserted with new a/b/op on cycles 3 and 9 of a running multiply -> ignored; a/b toggled mid-multiply -> result unchanged; exactly one done.
- Back-to-back: MUL then ADD 0x0002+0x0003 started in the MUL done cycle -> ADD done next cycle, result 0x0005.
- rst asserted on cycle 8 of a MUL -> next cycle all outputs 0, busy=0, no done pulse; a new ADD started after rst completes normally.
